// File: rtl/contador_pkg.sv
// ============================================================================
//  contador_pkg : shared direction constants and width helper for contador_modn
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package contador_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Smallest width whose range 0..2**w-1 covers 0..modulus-1.
   function automatic int min_width(input int modulus);
      int w;
      w = 1;
      for (int i = 1; i < 10; i++) begin
         if ((1 << i) < modulus) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/contador_modn_next.sv
// ============================================================================
//  contador_modn_next : next-value logic for one digit (wrap, load clamp, tc)
//  Revision           : 1.0
// ============================================================================
`default_nettype none

module contador_modn_next
   import contador_pkg::*;
#(
   parameter int MODULUS = 6,
   parameter int WIDTH   = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  logic             up,
   output logic [WIDTH-1:0] step_val,
   output logic [WIDTH-1:0] load_val,
   output logic             load_clamp,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS itself is representable when 2**WIDTH == MODULUS.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic at_max;
   logic at_min;

   always_comb begin
      at_max     = (count == MAX_VAL);
      at_min     = (count == '0);
      load_clamp = ({1'b0, data} >= MOD_EXT);
      load_val   = load_clamp ? MAX_VAL : data;
      if (up == DIR_UP) begin
         step_val = at_max ? '0 : count + WIDTH'(1);
      end else begin
         step_val = at_min ? MAX_VAL : count - WIDTH'(1);
      end
      tc = enable && ((up == DIR_UP) ? at_max : at_min);
   end

endmodule

`default_nettype wire

// File: rtl/contador_modn.sv
// ============================================================================
//  contador_modn : cascadable modulo-N counter with clamped parallel load
//  Optional up/down port enabled by macro CONTADOR_MODN_UPDOWN_EN
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module contador_modn
   import contador_pkg::*;
#(
   parameter int MODULUS     = 6,
   parameter int WIDTH       = 4,
   parameter int RESET_VALUE = 0
) (
   input  logic             clock,
   input  logic             clr,
   input  logic             loadn,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
`ifdef CONTADOR_MODN_UPDOWN_EN
   input  logic             up,
`endif
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             tc,
   output logic             clamped
);

   if (MODULUS < 2 || MODULUS > 256) begin : g_bad_modulus
      $error("contador_modn: MODULUS must be in 2..256");
   end
   if (WIDTH < min_width(MODULUS)) begin : g_bad_width
      $error("contador_modn: WIDTH too small for MODULUS");
   end
   if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("contador_modn: RESET_VALUE must be below MODULUS");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic             clamped_q, clamped_d;
   logic [WIDTH-1:0] step_val, load_val;
   logic             load_clamp;
   logic             dir;

`ifdef CONTADOR_MODN_UPDOWN_EN
   assign dir = up;
`else
   assign dir = DIR_DOWN;
`endif

   contador_modn_next #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_next (
      .count      (count_q),
      .data       (data),
      .enable     (enable),
      .up         (dir),
      .step_val   (step_val),
      .load_val   (load_val),
      .load_clamp (load_clamp),
      .tc         (tc)
   );

   // clr outranks everything and is applied in the register process.
   always_comb begin
      count_d   = count_q;
      clamped_d = 1'b0;
      if (!loadn) begin
         count_d   = load_val;
         clamped_d = load_clamp;
      end else if (enable) begin
         count_d = step_val;
      end
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         count_q   <= WIDTH'(RESET_VALUE);
         clamped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         clamped_q <= clamped_d;
      end
   end

   assign count   = count_q;
   assign zero    = (count_q == '0);
   assign clamped = clamped_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_modn.sv
// ============================================================================
//  tb_contador_modn : directed and randomized checks of contador_modn
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_contador_modn;

   localparam int M  = 6;
   localparam int W  = 4;
   localparam int RV = 0;

   logic         clk = 1'b0;
   logic         clr, loadn, enable, up;
   logic [W-1:0] data;
   logic [W-1:0] count;
   logic         zero, tc, clamped;

   // cascade pair: seconds (mod 10) feeding tens (mod 6)
   logic         cas_clr, cas_en;
   logic [3:0]   sec_count, ten_count;
   logic         sec_zero, sec_tc, sec_clamped;
   logic         ten_zero, ten_tc, ten_clamped;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   contador_modn #(.MODULUS(M), .WIDTH(W), .RESET_VALUE(RV)) dut (
      .clock   (clk),
      .clr     (clr),
      .loadn   (loadn),
      .enable  (enable),
      .data    (data),
`ifdef CONTADOR_MODN_UPDOWN_EN
      .up      (up),
`endif
      .count   (count),
      .zero    (zero),
      .tc      (tc),
      .clamped (clamped)
   );

   contador_modn #(.MODULUS(10), .WIDTH(4), .RESET_VALUE(0)) u_sec (
      .clock   (clk),
      .clr     (cas_clr),
      .loadn   (1'b1),
      .enable  (cas_en),
      .data    (4'd0),
`ifdef CONTADOR_MODN_UPDOWN_EN
      .up      (1'b0),
`endif
      .count   (sec_count),
      .zero    (sec_zero),
      .tc      (sec_tc),
      .clamped (sec_clamped)
   );

   contador_modn #(.MODULUS(6), .WIDTH(4), .RESET_VALUE(0)) u_ten (
      .clock   (clk),
      .clr     (cas_clr),
      .loadn   (1'b1),
      .enable  (sec_tc),
      .data    (4'd0),
`ifdef CONTADOR_MODN_UPDOWN_EN
      .up      (1'b0),
`endif
      .count   (ten_count),
      .zero    (ten_zero),
      .tc      (ten_tc),
      .clamped (ten_clamped)
   );

   // ---------------- behavioural reference model ----------------
   int m_count   = 0;
   bit m_clamped = 1'b0;
   bit m_valid   = 1'b0;

   function automatic bit model_up(input logic u);
`ifdef CONTADOR_MODN_UPDOWN_EN
      return (u === 1'b1);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      m_clamped = 1'b0;
      if (clr) begin
         m_count = RV;
         m_valid = 1'b1;
      end else if (!loadn) begin
         if (int'(data) < M) begin
            m_count = int'(data);
         end else begin
            m_count   = M - 1;
            m_clamped = 1'b1;
         end
      end else if (enable) begin
         if (model_up(up)) m_count = (m_count + 1) % M;
         else              m_count = (m_count + M - 1) % M;
      end
   end

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare process: every negedge once the model has seen clr.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_count",   int'(count), m_count);
         chk("model_zero",    int'(zero), int'(m_count == 0));
         chk("model_clamped", int'(clamped), int'(m_clamped));
         chk("model_tc",      int'(tc),
             int'(enable && (model_up(up) ? (m_count == M - 1) : (m_count == 0))));
      end
   end

   // inputs change 3 time units after the edge, well clear of both edges
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   initial begin
      int exp_cnt [4] = '{1, 0, 5, 4};
      int exp_tc  [4] = '{0, 1, 0, 0};

      clr = 1'b1; loadn = 1'b1; enable = 1'b0; data = '0; up = 1'b0;
      cas_clr = 1'b1; cas_en = 1'b0;

      // reset state
      tick();
      clr = 1'b0;
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_zero", int'(zero), 1);
      chk("rst_clamped", int'(clamped), 0);

      // down count from 2 through the wrap
      loadn = 1'b0; data = 4'd2;
      tick();
      loadn = 1'b1; enable = 1'b1; up = 1'b0;
      #1;
      chk("down_start", int'(count), 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk("down_seq", int'(count), exp_cnt[i]);
         chk("down_tc", int'(tc), exp_tc[i]);
      end

      // load wins over the wrap while tc is high at count 0
      loadn = 1'b0; data = 4'd0; enable = 1'b0;
      tick();
      data = 4'd3; enable = 1'b1;
      #1;
      chk("load_tc", int'(tc), 1);
      tick();
      loadn = 1'b1; enable = 1'b0;
      #1;
      chk("load_wins", int'(count), 3);
      chk("hold_tc", int'(tc), 0);

      // out-of-range load clamps to M-1 with a one-cycle flag
      loadn = 1'b0; data = 4'd9;
      tick();
      loadn = 1'b1;
      #1;
      chk("clamp_count", int'(count), 5);
      chk("clamp_flag", int'(clamped), 1);
      tick();
      #1;
      chk("clamp_flag_off", int'(clamped), 0);
      chk("hold_count", int'(count), 5);

`ifdef CONTADOR_MODN_UPDOWN_EN
      loadn = 1'b0; data = 4'd4;
      tick();
      loadn = 1'b1; enable = 1'b1; up = 1'b1;
      #1;
      chk("up_tc4", int'(tc), 0);
      tick(); #1;
      chk("up_5", int'(count), 5);
      chk("up_tc5", int'(tc), 1);
      tick(); #1;
      chk("up_0", int'(count), 0);
      chk("up_tc0", int'(tc), 0);
      tick(); #1;
      chk("up_1", int'(count), 1);
      up = 1'b0;
`endif

      // clr beats a simultaneous load and count
      clr = 1'b1; loadn = 1'b0; enable = 1'b1; data = 4'd3;
      tick();
      clr = 1'b0; loadn = 1'b1; enable = 1'b0;
      #1;
      chk("clr_wins", int'(count), RV);

      // cascade 00 -> 59, 58 ... 49, then clr mid-run
      cas_clr = 1'b0; cas_en = 1'b1;
      #1;
      chk("cas_start", int'(ten_count) * 10 + int'(sec_count), 0);
      for (int i = 0; i < 11; i++) begin
         tick(); #1;
         chk("cas_seq", int'(ten_count) * 10 + int'(sec_count), 59 - i);
      end
      cas_clr = 1'b1;
      tick(); #1;
      chk("cas_clr", int'(ten_count) * 10 + int'(sec_count), 0);
      cas_clr = 1'b0; cas_en = 1'b0;

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         clr    = ($urandom_range(0, 40) == 0);
         loadn  = ($urandom_range(0, 5) != 0);
         enable = ($urandom_range(0, 2) != 0);
         data   = W'($urandom_range(0, 15));
         up     = 1'($urandom_range(0, 1));
         tick();
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
